demux4_router: RTL
==================

// Module: demux4_router
// PURPOSE
//  Sequential 1-to-4 demultiplexer: the reverse direction of the mux4 data path.
//  A single valid/ready input stream carries data plus a 2-bit lane select.
//  Each beat is steered into one of four registered output lanes.
//  Each lane has its own valid/ready handshake and a 1-entry holding slot.
//  Sits between a shared producer (e.g. decode/writeback bus) and four independent consumers.
// PARAMETERS
//  W       8   data width per beat, in bits (legal range 1..32)
//  CNT_W   8   width of the per-lane accepted-beat counters
// PORTS
//  clk        in   1        clock; all state updates on posedge
//  rst        in   1        reset; asynchronous, active-high
//  in_valid   in   1        producer has a beat on in_data/in_sel
//  in_ready   out  1        router accepts the beat this cycle
//  in_data    in   W        beat payload
//  in_sel     in   2        destination lane: 0->lane0 .. 3->lane3
//  out_valid  out  4        per-lane: slot holds a beat
//  out_ready  in   4        per-lane: consumer takes the beat this cycle
//  out_data   out  4xW      per-lane slot contents (packed array [3:0][W-1:0])
//  acc_cnt    out  4xCNT_W  per-lane count of beats accepted into the slot
//  stall_cnt  out  CNT_W    cycles with in_valid=1 and in_ready=0
// BEHAVIOUR
//  Reset (async, while rst=1): out_valid=0, out_data=0, acc_cnt=0, stall_cnt=0.
//  Reset: in_ready is also forced to 0 while rst=1.
//  Reset mid-operation: any beats held in the slots are discarded; no beat is emitted afterwards.
//  Lane slot state, per lane i: EMPTY (out_valid[i]=0) or FULL (out_valid[i]=1).
//   Slot transitions:
//   - EMPTY: a load makes it FULL.
//   - FULL with out_ready[i]=1 and no load: goes to EMPTY.
//   - FULL with out_ready[i]=1 and a load in the same cycle: stays FULL with the new data.
//   - FULL with out_ready[i]=0: holds; out_data[i] stays stable.
//  Acceptance rule (combinational, no dependence on in_valid):
//   in_ready = ~rst & (~out_valid[in_sel] | out_ready[in_sel]).
//   A FULL lane that is draining this cycle may therefore be reloaded in the same cycle.
//  Handshake:
//   - Accept = in_valid & in_ready.
//   - On accept, the slot of lane in_sel loads in_data at that posedge.
//   - The beat appears on out_data next cycle, so latency is 1 clock.
//   - Only the addressed lane is involved: no head-of-line blocking from the other lanes.
//   - The other lanes are never written.
//  Consumer handshake: a lane transfer occurs when out_valid[i] & out_ready[i].
//  out_ready on an EMPTY lane is ignored.
//  Counters:
//   - acc_cnt[i] += 1 on each accept with in_sel=i.
//   - stall_cnt += 1 on each cycle with in_valid & ~in_ready.
//   - All counters wrap modulo 2**CNT_W (255 -> 0 for CNT_W=8) and never saturate.
//  Boundary cases:
//   - in_sel changing while in_valid=0 has no effect.
//   - in_ready may toggle with in_sel, so the producer must hold in_sel/in_data stable until accept.
//   - All four lanes FULL and stalled: every in_sel gives in_ready=0.
//  No X on outputs after reset deassertion.
// STRUCTURE
//  Package demux4_pkg holds:
//   - localparam NUM_LANES=4
//   - typedef logic [1:0] lane_sel_t
//   - typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t
//  Sub-module demux4_slot: one lane's 1-entry buffer plus its acc_cnt.
//  demux4_slot ports: clk, rst, load, data_in, ready, valid, data_out, cnt.
//  Top level: instantiate demux4_slot 4x via generate; decode in_sel into one-hot loads.
//  Top level also holds the in_ready mux and stall_cnt.
// TESTING
//  T1 reset: hold rst=1 mid-run with slots FULL.
//   Expect out_valid=0000, all counters 0, in_ready=0 asynchronously.
//  T2 single routing: with out_ready=1111, send W=8 beats A5->sel0, 3C->sel1, 0F->sel2, F0->sel3 on consecutive cycles.
//   Expect each beat on its lane 1 clk later.
//   Expect other lanes unchanged; acc_cnt={1,1,1,1}.
//  T3 backpressure: out_ready[2]=0, send 11 then 22 to sel2.
//   Expect 11 held on out_data[2]; in_ready=0 on beat 22 and stall_cnt increments per cycle.
//   Raise out_ready[2]: 22 is accepted that same cycle and appears next clk.
//  T4 no HOL: lane1 FULL and stalled, send 77 to sel3.
//   Expect accepted immediately, out_data[3]=77 next clk, lane1 still holding.
//  T5 wrap: send 256 beats to sel0 with out_ready[0]=1.
//   Expect acc_cnt[0]=0 after wrapping; stall_cnt=0.
//  T6 random self-check: 1000 random beats with random out_ready.
//   Scoreboard per-lane FIFO order; expect 0 mismatches and no drops.
//   Report counts with $display and finish with $stop.

Source files
------------

// File: rtl/demux4_pkg.sv
`default_nettype none
// ============================================================================
// Module  : demux4_pkg
// Purpose : Shared lane count, lane-select type and slot state encoding
//           for the 1-to-4 demultiplexing router.
// Rev     : 1.0  initial release
// ============================================================================
package demux4_pkg;

  localparam int NUM_LANES = 4;

  typedef logic [1:0] lane_sel_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage : demux4_pkg
`default_nettype wire

// File: rtl/demux4_slot.sv
`default_nettype none
// ============================================================================
// Module  : demux4_slot
// Purpose : One output lane of the router.
//           - 1-entry holding slot with a valid/ready handshake.
//           - Counter of beats loaded into the slot.
//           A load wins over a drain in the same cycle, so a draining slot
//           can be refilled without a bubble.
// Rev     : 1.0  initial release
// ============================================================================
module demux4_slot
  import demux4_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [W-1:0]     data_in,
  input  logic             ready,
  output logic             valid,
  output logic [W-1:0]     data_out,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  slot_state_t        r_state;
  logic [W-1:0]       r_data;
  logic [CNT_W-1:0]   r_cnt;

  // Slot occupancy, payload and accepted-beat count; load overrides drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SLOT_EMPTY;
      r_data  <= '0;
      r_cnt   <= '0;
    end else if (load) begin
      r_state <= SLOT_FULL;
      r_data  <= data_in;
      r_cnt   <= r_cnt + CNT_ONE;
    end else if ((r_state == SLOT_FULL) && ready) begin
      r_state <= SLOT_EMPTY;
    end
  end

  assign valid    = (r_state == SLOT_FULL);
  assign data_out = r_data;
  assign cnt      = r_cnt;

endmodule : demux4_slot
`default_nettype wire

// File: rtl/demux4_router.sv
`default_nettype none
// ============================================================================
// Module  : demux4_router
// Purpose : Sequential 1-to-4 demultiplexer.
//           - A single valid/ready input stream is steered by in_sel into
//             one of four registered lanes.
//           - Each lane has its own handshake.
//           - Only the addressed lane gates acceptance, so a stalled lane
//             never blocks traffic to the others.
// Rev     : 1.0  initial release
// ============================================================================
module demux4_router
  import demux4_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [W-1:0]                    in_data,
  input  lane_sel_t                       in_sel,
  output logic [NUM_LANES-1:0]            out_valid,
  input  logic [NUM_LANES-1:0]            out_ready,
  output logic [NUM_LANES-1:0][W-1:0]     out_data,
  output logic [NUM_LANES-1:0][CNT_W-1:0] acc_cnt,
  output logic [CNT_W-1:0]                stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic                 accept;
  logic [NUM_LANES-1:0] load;
  logic [CNT_W-1:0]     r_stall_cnt;

  // The addressed slot can take a beat when it is empty or being drained
  // this cycle; reset masks acceptance so nothing slips in during reset.
  assign in_ready = ~rst & (~out_valid[in_sel] | out_ready[in_sel]);
  assign accept   = in_valid & in_ready;

  generate
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      assign load[g] = accept & (in_sel == lane_sel_t'(g));

      demux4_slot #(
        .W     (W),
        .CNT_W (CNT_W)
      ) u_slot (
        .clk      (clk),
        .rst      (rst),
        .load     (load[g]),
        .data_in  (in_data),
        .ready    (out_ready[g]),
        .valid    (out_valid[g]),
        .data_out (out_data[g]),
        .cnt      (acc_cnt[g])
      );
    end
  endgenerate

  // Count producer cycles lost to a full, non-draining destination lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (in_valid && !in_ready) begin
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule : demux4_router
`default_nettype wire
